// File: rtl/pipelined_adder_if.sv
// Valid/ready operand and result streams of pipelined_adder; ovf_o exists only with PIPELINED_ADDER_OVF_EN.
// Direction suffixes are from the adder's point of view (slave = adder, master = source/sink).
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             c_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] s_o;
  logic             c_o;
`ifdef PIPELINED_ADDER_OVF_EN
  logic             ovf_o;

  modport slave (
    input  valid_i, a_i, b_i, c_i, ready_i,
    output ready_o, valid_o, s_o, c_o, ovf_o
  );

  modport master (
    output valid_i, a_i, b_i, c_i, ready_i,
    input  ready_o, valid_o, s_o, c_o, ovf_o
  );
`else
  modport slave (
    input  valid_i, a_i, b_i, c_i, ready_i,
    output ready_o, valid_o, s_o, c_o
  );

  modport master (
    output valid_i, a_i, b_i, c_i, ready_i,
    input  ready_o, valid_o, s_o, c_o
  );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// Chunked carry-ripple adder, one CHUNK-bit add per stage, latency STAGES, one op/cycle; bubbles collapse.
// ready_o is combinational from ready_i through the stage enables; PIPELINED_ADDER_OVF_EN adds registered ovf_o.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be >= 1 and divisible by STAGES");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] cy_q;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] v_in;
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] cy_d;
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  s_in  [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [CHUNK:0]    part  [STAGES];

  // A stage may advance if any stage from it to the output is empty, or the output drains.
  for (genvar k = 0; k < STAGES; k++) begin : g_en
    assign en[k] = bus.ready_i | ~(&v_q[STAGES-1:k]);
  end

  always_comb begin
    v_in    = '0;
    c_in    = '0;
    cy_d    = '0;
    v_in[0] = bus.valid_i;
    c_in[0] = bus.c_i;
    a_in[0] = bus.a_i;
    b_in[0] = bus.b_i;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      c_in[k] = cy_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = sum_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
               + (CHUNK+1)'(c_in[k]);
      sum_d[k] = s_in[k];
      sum_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      cy_d[k]  = part[k][CHUNK];
    end
  end

  // Data registers load only with a valid op so the output holds its last result across bubbles.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v_q  <= '0;
      cy_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k]   <= a_in[k];
            b_q[k]   <= b_in[k];
            sum_q[k] <= sum_d[k];
            cy_q[k]  <= cy_d[k];
          end
        end
      end
    end
  end

  assign bus.ready_o = en[0];
  assign bus.valid_o = v_q[STAGES-1];
  assign bus.s_o     = sum_q[STAGES-1];
  assign bus.c_o     = cy_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_comb begin
    ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
          ^ sum_d[STAGES-1][WIDTH-1] ^ cy_d[STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
    end else if (en[STAGES-1] && v_in[STAGES-1]) begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf_o = ovf_q;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed checks of pipelined_adder (WIDTH=32, STAGES=4): reset, ripple, streaming, stall, overflow, mid-op reset.
module tb_pipelined_adder;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  pipelined_adder_if #(.WIDTH(32)) bus ();

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic c);
    bus.valid_i = v;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.c_i     = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    bus.ready_i = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", bus.valid_o); end
    total++; if (bus.s_o !== 32'h0) begin bad++; $display("FAIL reset_sum: got %h expected 00000000", bus.s_o); end
    total++; if (bus.c_o !== 1'b0) begin bad++; $display("FAIL reset_carry: got %b expected 0", bus.c_o); end
`ifdef PIPELINED_ADDER_OVF_EN
    total++; if (bus.ovf_o !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf_o); end
`endif
    total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b expected 1", bus.ready_o); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      bad++; $display("FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0", bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_ripple();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (cyc == 3) begin
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL ripple_latency_early: got valid=%b expected 0", bus.valid_o); end
      end
      if (cyc == 4) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== 32'h0 || bus.c_o !== 1'b1) begin
          bad++; $display("FAIL ripple_result: got valid=%b s=%h c=%b expected valid=1 s=00000000 c=1", bus.valid_o, bus.s_o, bus.c_o);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        total++; if (bus.ovf_o !== 1'b0) begin bad++; $display("FAIL ripple_ovf: got %b expected 0", bus.ovf_o); end
`endif
      end
      if (cyc == 0) drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_stream();
    logic [31:0] ea [3];
    logic [31:0] eb [3];
    logic        ec [3];
    logic [31:0] es [3];
    ea = '{32'h1, 32'h10, 32'hFFFF};
    eb = '{32'h2, 32'h20, 32'h1};
    ec = '{1'b1, 1'b0, 1'b0};
    es = '{32'h4, 32'h30, 32'h1_0000};
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (cyc >= 4 && cyc <= 6) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== es[cyc-4]) begin
          bad++; $display("FAIL stream_out%0d: got valid=%b s=%h expected valid=1 s=%h", cyc-4, bus.valid_o, bus.s_o, es[cyc-4]);
        end
      end
      if (cyc == 7) begin
        total++; if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL stream_end: got valid=%b expected 0", bus.valid_o); end
      end
      if (cyc < 3) drive(1'b1, ea[cyc], eb[cyc], ec[cyc]);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ea [6];
    logic [31:0] eb [6];
    logic        ec [6];
    logic [31:0] es [6];
    logic [31:0] got [$];
    int          idx;
    logic        sent;
    ea = '{32'h1, 32'h2, 32'h100, 32'hFFFF_FFFF, 32'h1234_5678, 32'hA};
    eb = '{32'h1, 32'h3, 32'h200, 32'hFFFF_FFFF, 32'h1111_1111, 32'h5};
    ec = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    es = '{32'h2, 32'h5, 32'h301, 32'hFFFF_FFFE, 32'h2345_6789, 32'h10};
    idx  = 0;
    sent = 1'b0;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      if (sent) idx++;
      if (cyc == 4) begin
        total++; if (bus.ready_o !== 1'b0 || idx != 4) begin
          bad++; $display("FAIL bp_full: got ready=%b accepted=%0d expected ready=0 accepted=4", bus.ready_o, idx);
        end
      end
      if (cyc == 5) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== 32'h2) begin
          bad++; $display("FAIL bp_hold: got valid=%b s=%h expected valid=1 s=00000002", bus.valid_o, bus.s_o);
        end
      end
      bus.ready_i = (cyc >= 5);
      if (idx < 6) drive(1'b1, ea[idx], eb[idx], ec[idx]);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
      #1;
      sent = bus.valid_i && bus.ready_o;
      if (bus.valid_o && bus.ready_i) got.push_back(bus.s_o);
    end
    total++; if (got.size() != 6) begin bad++; $display("FAIL bp_count: got %0d results expected 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        total++; if (got[i] !== es[i]) begin bad++; $display("FAIL bp_order%0d: got %h expected %h", i, got[i], es[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 7; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== 32'h8000_0000 || bus.c_o !== 1'b0) begin
          bad++; $display("FAIL ovf_pos: got valid=%b s=%h c=%b expected valid=1 s=80000000 c=0", bus.valid_o, bus.s_o, bus.c_o);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        total++; if (bus.ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_pos_flag: got %b expected 1", bus.ovf_o); end
`endif
      end
      if (cyc == 5) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== 32'h0 || bus.c_o !== 1'b1) begin
          bad++; $display("FAIL ovf_neg: got valid=%b s=%h c=%b expected valid=1 s=00000000 c=1", bus.valid_o, bus.s_o, bus.c_o);
        end
`ifdef PIPELINED_ADDER_OVF_EN
        total++; if (bus.ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_neg_flag: got %b expected 1", bus.ovf_o); end
`endif
      end
      if (cyc == 0) drive(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0);
      else if (cyc == 1) drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  task automatic test_reset_mid();
    int stale;
    bus.ready_i = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        total++; if (bus.valid_o !== 1'b1) begin bad++; $display("FAIL midrst_pre: got valid=%b expected 1", bus.valid_o); end
      end
      if (cyc == 0) drive(1'b1, 32'h3, 32'h4, 1'b0);
      else if (cyc == 1) drive(1'b1, 32'h5, 32'h5, 1'b0);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      bad++; $display("FAIL midrst_async: got valid=%b ready=%b expected valid=0 ready=1", bus.valid_o, bus.ready_o);
    end
    #1 rst_n = 1'b1;
    stale = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (bus.valid_o !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale: got %0d valid cycles expected 0", stale); end
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 4) begin
        total++; if (bus.valid_o !== 1'b1 || bus.s_o !== 32'hB) begin
          bad++; $display("FAIL midrst_new: got valid=%b s=%h expected valid=1 s=0000000b", bus.valid_o, bus.s_o);
        end
      end
      if (cyc == 0) drive(1'b1, 32'h5, 32'h6, 1'b0);
      else drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ready_i = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    test_reset();
    test_ripple();
    test_stream();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit binary adder with carry-in, carry-out and a valid/ready stream handshake. The operand word is split into STAGES equal chunks; each pipeline stage adds one chunk and passes its carry to the next stage, so the critical path is one CHUNK-bit add regardless of WIDTH. Used in the execute path and address-generation units wherever a wide add must close timing at the core clock and can tolerate fixed latency. Throughput is one addition per cycle.

## Interface
- WIDTH, default 32: operand and sum width in bits; must be ≥ 1.
- STAGES, default 4: number of pipeline stages. WIDTH % STAGES must equal 0, otherwise `$error` at elaboration. CHUNK = WIDTH/STAGES.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  a_i, b_i and c_i are valid this cycle.
- ready_o  output  1  adder accepts an operation this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- c_i  input  1  carry-in.
- valid_o  output  1  s_o and c_o (and ovf_o) hold a valid result.
- ready_i  input  1  downstream accepts the result this cycle.
- s_o  output  WIDTH  sum, (a_i + b_i + c_i) mod 2^WIDTH.
- c_o  output  1  carry out of bit WIDTH-1.
- ovf_o  output  1  signed overflow; present only with PIPELINED_ADDER_OVF_EN.

## Operation
- Stage k (0..STAGES-1) holds a valid bit v[k], the finished low sum bits [CHUNK·(k+1)-1:0], the chunk carry, and the still-unprocessed upper operand bits of A and B.
- Stage 0 adds chunk 0 of A and B plus c_i. Stage k adds chunk k of the skewed operands plus the carry registered in stage k-1. Every chunk add is a plain CHUNK-bit add with carry; the block contains no carry-lookahead across chunks.
- Advance enables: en[STAGES-1] = !v[STAGES-1] || ready_i; en[k] = !v[k] || en[k+1]. A stage loads only when its enable is high. Empty stages (bubbles) collapse.
- ready_o = en[0]. This is combinational from ready_i through the enable chain. A transfer in occurs when valid_i && ready_o.
- v[k] loads the incoming valid when en[k] is high. When en[k] is low, v[k] and the stage data hold.
- valid_o = v[STAGES-1]. s_o, c_o and ovf_o are driven directly from the last-stage registers and hold stable while valid_o && !ready_i.
- Results leave in acceptance order. No operation is dropped or duplicated.
- A 1-bit WIDTH with STAGES=1 degenerates to a registered full adder.

## Timing
- Reset (rst_n_i low, asynchronous): all v[k] = 0 and all data registers = 0. Therefore valid_o = 0, s_o = 0, c_o = 0, ovf_o = 0. ready_o = 1 while in reset and after release.
- Reset mid-operation: in-flight operations are discarded. valid_o falls without waiting for a clock edge. No stale result appears after release.
- Latency: an operation accepted at rising edge N appears with valid_o = 1 in the cycle after edge N+STAGES-1, i.e. STAGES cycles. With STAGES=1, the result is valid one cycle after acceptance.
- Full pipeline under stall: at most STAGES operations are in flight. With ready_i low and all v[k] = 1, ready_o = 0.
- Simultaneous events: with the pipeline full, ready_i = 1 and valid_i = 1 in the same cycle, the output is accepted and a new input is accepted on the same edge. Throughput is maintained.
- valid_i may be asserted without waiting for ready_o. Input data are sampled only on a transfer.

## Configuration
- PIPELINED_ADDER_OVF_EN defined:
  - Port ovf_o exists.
  - The last stage computes ovf_o = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - ovf_o is registered alongside s_o and c_o, with identical timing and reset value 0.
- PIPELINED_ADDER_OVF_EN undefined:
  - Port ovf_o is absent.
  - No overflow logic is present.
  - All other behaviour is unchanged.

## Test plan
All scenarios use WIDTH=32, STAGES=4, with PIPELINED_ADDER_OVF_EN defined.
- Reset: hold rst_n_i low -> valid_o=0, s_o=0x0, c_o=0, ovf_o=0, ready_o=1.
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001, c_i=0 accepted at edge N -> valid_o=1 after edge N+3, s_o=0x00000000, c_o=1, ovf_o=0.
- Streaming with ready_i=1: accept 0x1+0x2 (c_i=1), 0x10+0x20, 0xFFFF+0x1 on consecutive edges -> valid_o high for 3 consecutive cycles with s_o=0x4, then 0x30, then 0x10000.
- Backpressure: stream 6 operations while ready_i=0 for 5 cycles -> ready_o falls after 4 acceptances; after ready_i returns high, all 6 results emerge in order with no loss or duplication; s_o is stable while stalled.
- Overflow: 0x7FFFFFFF+0x1 -> s_o=0x80000000, c_o=0, ovf_o=1. Then 0x80000000+0x80000000 -> s_o=0x0, c_o=1, ovf_o=1.
- Reset mid-operation: 2 operations in flight, rst_n_i pulsed low between edges -> valid_o drops immediately; after release, valid_o stays 0 until a new operation is accepted.
